// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, decode-side instruction stream, redirect.
// Every valid/ready pair transfers on a clock edge where both are high; valid never waits on ready.
interface ifetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: sequential PC issue under a DEPTH credit limit, in-order response FIFO,
// redirect flush with stale-response dropping. Optional same-cycle response bypass: IFETCH_BYPASS_EN.
module ifetch_queue #(
  parameter int          DEPTH   = 4,
  parameter logic [63:0] PC_INIT = 64'h0
) (
  input  logic           clk,
  input  logic           rst,
  ifetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [31:0]      buf_data [DEPTH];
  logic [63:0]      buf_pc   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop;
  logic [63:0]      fetch_pc;
  logic [63:0]      rsp_pc;

  logic [CNT_W-1:0] inflight_live;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W-1:0] rsp_dec;
  logic [63:0]      redirect_base;
  logic             fifo_empty;
  logic             fifo_full;
  logic             req_fire;
  logic             rsp_live;
  logic             rsp_drop;
  logic             bypass;
  logic             push;
  logic             pop;

  // Credits cover both buffered words and live in-flight fetches, so the FIFO can never overflow.
  assign inflight_live = inflight - drop;
  assign occupancy     = {1'b0, count} + {1'b0, inflight_live};
  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == DEPTH_CNT);
  assign rsp_dec       = CNT_W'(bus.imem_rsp_valid);
  assign redirect_base = bus.redirect_pc & ~64'h3;

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (occupancy < DEPTH_OCC);
  assign bus.imem_addr      = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A response landing in a redirect cycle is stale by definition and is never kept.
  assign rsp_live = !rst && bus.imem_rsp_valid && !bus.redirect_valid && (drop == '0);
  assign rsp_drop = !rst && bus.imem_rsp_valid && !bus.redirect_valid && (drop != '0);

`ifdef IFETCH_BYPASS_EN
  assign bypass      = fifo_empty && rsp_live;
  assign bus.inst    = bypass ? bus.imem_rsp_data : buf_data[rd_ptr];
  assign bus.inst_pc = bypass ? rsp_pc : buf_pc[rd_ptr];
`else
  assign bypass      = 1'b0;
  assign bus.inst    = buf_data[rd_ptr];
  assign bus.inst_pc = buf_pc[rd_ptr];
`endif

  assign bus.inst_valid = !rst && !bus.redirect_valid && (!fifo_empty || bypass);
  assign pop            = bus.inst_valid && bus.inst_ready && !fifo_empty;
  // A bypassed word consumed in the same cycle never enters the FIFO.
  assign push           = rsp_live && !(bypass && bus.inst_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= PC_INIT;
      rsp_pc   <= PC_INIT;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc <= redirect_base;
      rsp_pc   <= redirect_base;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= inflight - rsp_dec;
      drop     <= inflight - rsp_dec;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 64'd4;
      if (rsp_live) rsp_pc <= rsp_pc + 64'd4;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (rsp_drop) drop <= drop - CNT_W'(1);
      inflight <= inflight + CNT_W'(req_fire) - rsp_dec;
      count    <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= bus.imem_rsp_data;
      buf_pc[wr_ptr]   <= rsp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));
  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rsp_valid && (inflight == '0)));
  a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
    drop <= inflight);
endmodule
